// File: rtl/axis_crc_pkg.sv
// Shared state type, packet-counter width and the one-cycle CRC fold used by axis_crc_append.
package axis_crc_pkg;

  typedef enum logic {
    PASS   = 1'b0,
    APPEND = 1'b1
  } crc_state_t;

  localparam int PKT_CNT_W  = 16;
  localparam int MAX_DATA_W = 256;

  // The CRC is left-aligned in a 32-bit working register so a single loop serves every crc_w;
  // data is left-aligned too so its MSB is always folded first.
  function automatic logic [31:0] crc_next(
    input logic [31:0]           crc,
    input logic [MAX_DATA_W-1:0] data,
    input logic [31:0]           poly,
    input int                    data_w,
    input int                    crc_w
  );
    logic [31:0]           c;
    logic [31:0]           p;
    logic [MAX_DATA_W-1:0] d;
    logic                  fb;
    c  = crc << (32 - crc_w);
    p  = poly << (32 - crc_w);
    d  = data << (MAX_DATA_W - data_w);
    fb = 1'b0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        fb = c[31] ^ d[MAX_DATA_W-1];
        c  = (c << 1) ^ (fb ? p : 32'h0);
        d  = d << 1;
      end
    end
    return (c >> (32 - crc_w)) & (32'hFFFF_FFFF >> (32 - crc_w));
  endfunction

endpackage

// File: rtl/axis_crc_append_if.sv
// AXI-Stream beat bundle (tdata/tvalid/tlast/tready) with source (master) and sink (slave) views.
interface axis_crc_append_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_crc_append.sv
// CRC appender: 1-cycle registered pass-through, then one CRC beat with tlast; input stalls one cycle per packet
// and output backpressure propagates to s_axis.tready. `AXIS_CRC_PKT_CNT_EN adds the pkt_count output.
module axis_crc_append
  import axis_crc_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          CRC_WIDTH  = 32,
  parameter logic [31:0] POLY       = 32'h04C1_1DB7,
  parameter logic [31:0] INIT       = 32'hFFFF_FFFF,
  parameter logic [31:0] XOR_OUT    = 32'h0000_0000
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_crc_append_if.slave     s_axis,
  axis_crc_append_if.master    m_axis,
  output logic                 crc_done,
  output logic [CRC_WIDTH-1:0] crc_value
`ifdef AXIS_CRC_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_count
`endif
);

  crc_state_t            state;
  crc_state_t            state_nxt;
  logic [CRC_WIDTH-1:0]  crc_run;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_vld;
  logic                  out_lst;
  logic                  out_free;
  logic                  in_hs;
  logic                  crc_hs;
  logic                  load_crc;

  assign out_free = !out_vld || m_axis.tready;
  assign in_hs    = s_axis.tvalid && s_axis.tready;
  assign crc_hs   = out_vld && out_lst && m_axis.tready;

  always_ff @(posedge aclk) begin
    if (areset) state <= PASS;
    else        state <= state_nxt;
  end

  // APPEND lasts only until the CRC beat is in the output register, so the next packet's
  // first beat can load while the CRC beat drains.
  always_comb begin
    state_nxt = state;
    case (state)
      PASS:    if (in_hs && s_axis.tlast) state_nxt = APPEND;
      APPEND:  if (out_free) state_nxt = PASS;
      default: state_nxt = PASS;
    endcase
  end

  always_comb begin
    s_axis.tready = 1'b0;
    load_crc      = 1'b0;
    case (state)
      PASS:    s_axis.tready = out_free && !areset;
      APPEND:  load_crc = out_free;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      crc_run <= INIT[CRC_WIDTH-1:0];
      out_dat <= '0;
      out_vld <= 1'b0;
      out_lst <= 1'b0;
    end else begin
      if (in_hs)
        crc_run <= CRC_WIDTH'(crc_next(32'(crc_run), MAX_DATA_W'(s_axis.tdata), POLY,
                                       DATA_WIDTH, CRC_WIDTH));
      else if (load_crc)
        crc_run <= INIT[CRC_WIDTH-1:0];

      if (in_hs) begin
        out_dat <= s_axis.tdata;
        out_vld <= 1'b1;
        out_lst <= 1'b0;
      end else if (load_crc) begin
        out_dat <= DATA_WIDTH'(crc_run ^ XOR_OUT[CRC_WIDTH-1:0]);
        out_vld <= 1'b1;
        out_lst <= 1'b1;
      end else if (m_axis.tready) begin
        out_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      crc_done  <= 1'b0;
      crc_value <= '0;
    end else begin
      crc_done <= crc_hs;
      if (crc_hs) crc_value <= out_dat[CRC_WIDTH-1:0];
    end
  end

`ifdef AXIS_CRC_PKT_CNT_EN
  always_ff @(posedge aclk) begin
    if (areset)      pkt_count <= '0;
    else if (crc_hs) pkt_count <= pkt_count + 1'b1;
  end
`endif

  assign m_axis.tdata  = out_dat;
  assign m_axis.tvalid = out_vld;
  assign m_axis.tlast  = out_lst;

endmodule
